thread_scheduler: RTL and testbench
===================================

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters; only the value 4 is supported.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  4  bit k set: requester k has an operation pending.
REQ-005 req_op  input  32  operation for requester k in bits [8k+7:8k]: {dst[7:6], src_a[5:4], src_b[3:2], op[1:0]}.
REQ-006 req_ready  output  4  one-hot or zero; bit k set: req_op[k] is accepted this cycle.
REQ-007 en_write  output  1  register-file write enable to the thread datapath.
REQ-008 write_id  output  2  register-file write index.
REQ-009 read_id  output  2  register-file read index.
REQ-010 en_a  output  1  load ALU input A from the RF stage register.
REQ-011 en_b  output  1  load ALU input B from the RF stage register.
REQ-012 alu_op  output  2  ALU opcode.
REQ-013 en_alu_out  output  1  capture the ALU result into the EX/WB register.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse in the WB state.
REQ-016 done_id  output  2  requester index of the operation in WB; valid while done=1.

Function
REQ-017 FSM states: IDLE, RDA, RDB, LDB, EXE, WB; each non-IDLE state lasts exactly one cycle.
REQ-018 Fixed sequence: RDA->RDB->LDB->EXE->WB.
REQ-019 Accept window is IDLE or WB only; in any other state req_ready=0.
REQ-020 In the accept window with any req_valid set, grant the first set bit searching ptr, ptr+1, ... mod 4; drive req_ready[g]=1 that cycle.
REQ-021 On accept, latch dst/src_a/src_b/op and g; next state RDA.
REQ-022 In the accept window with no req_valid set, next state is IDLE.
REQ-023 After a grant to g, ptr becomes (g+1) mod 4; ptr is unchanged when nothing is granted.
REQ-024 Outputs per state (all others 0):
- RDA: read_id=src_a.
- RDB: read_id=src_b, en_a=1.
- LDB: en_b=1.
- EXE: en_alu_out=1, alu_op=op.
- WB: en_write=1, write_id=dst, done=1, done_id=g.
REQ-025 read_id, write_id and alu_op are 0 in states where they are not listed.
REQ-026 Outputs depend only on registered state; no combinational path from req_valid/req_op to any datapath output. req_ready is the only combinational function of req_valid.
REQ-027 Back-to-back: with a request pending in WB, the next RDA follows in the next cycle, giving a sustained rate of 1 op per 5 cycles. RDA reads the rf value written in the preceding WB.
REQ-028 A req_valid bit dropped before it is granted is simply not served; no error is flagged.
REQ-029 Grant latency: RDA occurs 1 cycle after the accept cycle, and WB occurs 5 cycles after it.

Reset
REQ-030 While rst=1: state=IDLE, ptr=0, latched fields=0, and every output=0, independent of clk.
REQ-031 Reset mid-operation abandons the operation; no en_write is issued for it after reset releases.

Structure
REQ-032 The shared package holds the state encoding enum, the req_op field offsets and ALU opcode constants.
REQ-033 One sub-module, rr_arbiter4 (4-bit round-robin priority pick from ptr), is instantiated once.

Verification
REQ-034 Single op: after reset, req_valid=0001, req_op[7:0]={dst=3,a=1,b=2,op=1} -> req_ready=0001 same cycle; read_id=1, then en_a with read_id=2, then en_b, then en_alu_out with alu_op=1, then en_write with write_id=3, done_id=0 at +5 cycles.
REQ-035 Fairness: req_valid=1111 held for 20 ops -> grant order 0,1,2,3,0,... with exactly one grant every 5 cycles.
REQ-036 Pointer skip: ptr=2 and req_valid=0011 -> grant 0, then ptr=1.
REQ-037 RAW chain: op r1=r0+r0 followed by op r2=r1+r1 back-to-back -> WB of the second op writes 4x the initial r0 value (ALU add).
REQ-038 Reset during EXE -> all outputs 0 immediately, and no en_write pulse within the following 10 cycles with req_valid=0.
REQ-039 Hold: req_valid set in RDB..EXE -> req_ready stays 0 until WB.

Source files
------------

// File: rtl/thread_scheduler_pkg.sv
// Shared definitions for the thread scheduler.
//   - state_t      : FSM state encoding
//   - op_fields_t  : decoded 8-bit requester operation {dst, src_a, src_b, op}
//   - ctrl_t       : bundle of registered datapath control outputs
//   - FLD_*_LSB    : bit offsets of the fields inside one 8-bit req_op slice
//   - ALU_*        : ALU opcode values carried in the op field
package thread_scheduler_pkg;

    localparam int REQ_COUNT     = 4;
    localparam int OP_W          = 8;

    localparam int FLD_OP_LSB    = 0;
    localparam int FLD_SRC_B_LSB = 2;
    localparam int FLD_SRC_A_LSB = 4;
    localparam int FLD_DST_LSB   = 6;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_LDB  = 3'd3,
        ST_EXE  = 3'd4,
        ST_WB   = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] dst;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] op;
    } op_fields_t;

    typedef struct packed {
        logic       en_write;
        logic [1:0] write_id;
        logic [1:0] read_id;
        logic       en_a;
        logic       en_b;
        logic [1:0] alu_op;
        logic       en_alu_out;
        logic       busy;
        logic       done;
        logic [1:0] done_id;
    } ctrl_t;

    // Split one 8-bit requester operation into its named fields.
    function automatic op_fields_t unpack_op(input logic [OP_W-1:0] raw);
        op_fields_t f;
        f.dst   = raw[FLD_DST_LSB   +: 2];
        f.src_a = raw[FLD_SRC_A_LSB +: 2];
        f.src_b = raw[FLD_SRC_B_LSB +: 2];
        f.op    = raw[FLD_OP_LSB    +: 2];
        return f;
    endfunction

endpackage

// File: rtl/thread_scheduler_rr_arbiter4.sv
// rr_arbiter4: purely combinational 4-way round-robin pick.
// The first set bit of 'valid' found when searching ptr, ptr+1, ... (mod 4)
// wins.
//   valid       in  [3:0] pending requests
//   ptr         in  [1:0] highest-priority index this cycle
//   grant       out [3:0] one-hot winner, zero when nothing is valid
//   grant_id    out [1:0] index of the winner (0 when nothing is valid)
//   grant_valid out       at least one request is valid
module rr_arbiter4
    import thread_scheduler_pkg::*;
(
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid
);

    logic [1:0] idx_s;
    logic [1:0] id_s;
    logic       found_s;

    // Scan from the farthest offset down to ptr itself so the nearest hit
    // to ptr is the one left standing.
    always_comb begin
        idx_s   = 2'd0;
        id_s    = 2'd0;
        found_s = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            idx_s   = ptr + 2'(i);
            id_s    = valid[idx_s] ? idx_s : id_s;
            found_s = valid[idx_s] | found_s;
        end
        grant_id    = id_s;
        grant_valid = found_s;
        grant       = found_s ? (4'b0001 << id_s) : 4'b0000;
    end

endmodule

// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin scheduler for a 5-stage thread datapath.
// One operation is accepted in IDLE or WB, then walked through
// RDA -> RDB -> LDB -> EXE -> WB, one cycle per state. All datapath controls
// are registered; req_ready is the only combinational output.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid  in  [3:0]     pending requests
//   req_op     in  [31:0]    per-requester {dst, src_a, src_b, op} bytes
//   req_ready  out [3:0]     one-hot accept strobe
//   en_write / write_id      register-file write
//   read_id                  register-file read index
//   en_a / en_b              ALU operand loads
//   alu_op / en_alu_out      ALU opcode and result capture
//   busy                     not IDLE
//   done / done_id           WB pulse and requester index
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 en_write,
    output logic [1:0]           write_id,
    output logic [1:0]           read_id,
    output logic                 en_a,
    output logic                 en_b,
    output logic [1:0]           alu_op,
    output logic                 en_alu_out,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           done_id
);

    state_t     state_r, state_s;
    op_fields_t fld_r, fld_s;
    logic [1:0] gid_r, gid_s;
    logic [1:0] ptr_r, ptr_s;
    ctrl_t      ctrl_r, ctrl_s;
    logic       accept_s;

    logic [3:0] grant_s;
    logic [1:0] grant_id_s;
    logic       grant_valid_s;

    rr_arbiter4 u_arb (
        .valid       (req_valid),
        .ptr         (ptr_r),
        .grant       (grant_s),
        .grant_id    (grant_id_s),
        .grant_valid (grant_valid_s)
    );

    // Next-state, operation latch and round-robin pointer update.
    always_comb begin
        state_s  = state_r;
        fld_s    = fld_r;
        gid_s    = gid_r;
        ptr_s    = ptr_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_WB: begin
                accept_s = 1'b1;
                if (grant_valid_s) begin
                    state_s = ST_RDA;
                    fld_s   = unpack_op(req_op[{grant_id_s, 3'b000} +: OP_W]);
                    gid_s   = grant_id_s;
                    ptr_s   = grant_id_s + 2'd1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RDA:  state_s = ST_RDB;
            ST_RDB:  state_s = ST_LDB;
            ST_LDB:  state_s = ST_EXE;
            ST_EXE:  state_s = ST_WB;
            default: state_s = ST_IDLE;
        endcase
    end

    // Decode the controls for the state being entered so they can be
    // registered and line up with state_r after the edge.
    always_comb begin
        ctrl_s      = '0;
        ctrl_s.busy = (state_s != ST_IDLE);
        case (state_s)
            ST_RDA: ctrl_s.read_id = fld_s.src_a;
            ST_RDB: begin
                ctrl_s.read_id = fld_s.src_b;
                ctrl_s.en_a    = 1'b1;
            end
            ST_LDB: ctrl_s.en_b = 1'b1;
            ST_EXE: begin
                ctrl_s.en_alu_out = 1'b1;
                ctrl_s.alu_op     = fld_s.op;
            end
            ST_WB: begin
                ctrl_s.en_write = 1'b1;
                ctrl_s.write_id = fld_s.dst;
                ctrl_s.done     = 1'b1;
                ctrl_s.done_id  = gid_s;
            end
            ST_IDLE: ctrl_s = '0;
            default: ctrl_s = '0;
        endcase
    end

    // State, latched operation, pointer and registered controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            fld_r   <= '0;
            gid_r   <= 2'd0;
            ptr_r   <= 2'd0;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_s;
            fld_r   <= fld_s;
            gid_r   <= gid_s;
            ptr_r   <= ptr_s;
            ctrl_r  <= ctrl_s;
        end
    end

    // rst is folded in so the strobe is forced low while reset is held,
    // even if requests are pending.
    assign req_ready  = (accept_s && !rst) ? grant_s : 4'b0000;

    assign en_write   = ctrl_r.en_write;
    assign write_id   = ctrl_r.write_id;
    assign read_id    = ctrl_r.read_id;
    assign en_a       = ctrl_r.en_a;
    assign en_b       = ctrl_r.en_b;
    assign alu_op     = ctrl_r.alu_op;
    assign en_alu_out = ctrl_r.en_alu_out;
    assign busy       = ctrl_r.busy;
    assign done       = ctrl_r.done;
    assign done_id    = ctrl_r.done_id;

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler. Expected behaviour comes from a
// per-cycle timeline: each accepted operation books its five stage slots
// (RDA..WB) in a table indexed by absolute cycle number. A small register
// file + ALU driven by the DUT controls checks the data flow end to end.
module tb_thread_scheduler;

    localparam int NCYC = 8192;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_op;
    logic [3:0]  req_ready;
    logic        en_write;
    logic [1:0]  write_id;
    logic [1:0]  read_id;
    logic        en_a;
    logic        en_b;
    logic [1:0]  alu_op;
    logic        en_alu_out;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;

    thread_scheduler #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .en_write   (en_write),
        .write_id   (write_id),
        .read_id    (read_id),
        .en_a       (en_a),
        .en_b       (en_b),
        .alu_op     (alu_op),
        .en_alu_out (en_alu_out),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // timeline model: stage number (0 = free, 1..5 = RDA..WB), op byte, requester
    int         cyc = 0;
    int         m_ptr = 0;
    int         ph  [NCYC];
    logic [7:0] opf [NCYC];
    int         gidt[NCYC];
    int         last_grant;

    // bench-side datapath
    logic [7:0] rf [4];
    logic [7:0] rf_q, a_q, b_q, alu_q;
    int         wr_count = 0;
    logic [1:0] last_wr_id;
    logic [7:0] last_wr_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [7:0] mk_op(input int dst, input int sa, input int sb, input int op);
        return {2'(dst), 2'(sa), 2'(sb), 2'(op)};
    endfunction

    // One clock cycle: drive, check against the timeline, book any grant,
    // advance the bench datapath, then cross the rising edge.
    task automatic step(input logic [3:0] v, input logic [31:0] op);
        int p;
        int g;
        int idx;
        logic [7:0] f;
        logic [3:0] exp_rdy;
        logic [7:0] n_rf_q, n_a, n_b, n_alu;
        @(negedge clk);
        req_valid = v;
        req_op    = op;
        #1;
        p = ph[cyc];
        f = opf[cyc];
        check_eq("en_write",   en_write,   p == 5);
        check_eq("write_id",   write_id,   (p == 5) ? f[7:6] : 2'd0);
        check_eq("read_id",    read_id,    (p == 1) ? f[5:4] : (p == 2) ? f[3:2] : 2'd0);
        check_eq("en_a",       en_a,       p == 2);
        check_eq("en_b",       en_b,       p == 3);
        check_eq("en_alu_out", en_alu_out, p == 4);
        check_eq("alu_op",     alu_op,     (p == 4) ? f[1:0] : 2'd0);
        check_eq("busy",       busy,       p != 0);
        check_eq("done",       done,       p == 5);
        check_eq("done_id",    done_id,    (p == 5) ? gidt[cyc] : 0);
        g = -1;
        exp_rdy = 4'b0000;
        if (p == 0 || p == 5) begin
            for (int i = 0; i < 4; i++) begin
                idx = (m_ptr + i) % 4;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            exp_rdy = 4'b0001 << g;
            for (int k = 1; k <= 5; k++) begin
                ph[cyc + k]   = k;
                opf[cyc + k]  = op[8*g +: 8];
                gidt[cyc + k] = g;
            end
            m_ptr = (g + 1) % 4;
        end
        check_eq("req_ready", req_ready, exp_rdy);
        last_grant = g;
        n_rf_q = rf[read_id];
        n_a    = en_a ? rf_q : a_q;
        n_b    = en_b ? rf_q : b_q;
        n_alu  = en_alu_out ? alu(a_q, b_q, alu_op) : alu_q;
        if (en_write) begin
            rf[write_id] = alu_q;
            wr_count++;
            last_wr_id  = write_id;
            last_wr_val = alu_q;
        end
        rf_q  = n_rf_q;
        a_q   = n_a;
        b_q   = n_b;
        alu_q = n_alu;
        @(posedge clk);
        cyc++;
    endtask

    // Assert reset mid-cycle: outputs must drop at once and stay low.
    task automatic apply_reset();
        @(negedge clk);
        #1;
        check_eq("pre_rst_exe", en_alu_out, ph[cyc] == 4);
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check_eq("rst_outs", {req_ready, en_write, write_id, read_id, en_a, en_b,
                              alu_op, en_alu_out, busy, done, done_id}, 0);
        m_ptr = 0;
        for (int i = cyc; i < NCYC; i++) ph[i] = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_hold", {req_ready, en_write, busy, done, read_id, write_id}, 0);
        cyc += 2;
        rst = 1'b0;
    endtask

    int   n_gr;
    int   wr_before;
    logic [7:0] x0;

    initial begin
        rst = 1'b1;
        req_valid = 4'h0;
        req_op = 32'h0;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        rf_q = 8'h00; a_q = 8'h00; b_q = 8'h00; alu_q = 8'h00;
        last_wr_id = 2'd0; last_wr_val = 8'h00;
        #2;
        apply_reset();

        // single op: dst=3, a=1, b=2, op=1 from requester 0
        step(4'b0001, {24'h0, mk_op(3, 1, 2, 1)});
        check_eq("single_grant", last_grant, 0);
        repeat (5) step(4'b0000, 32'h0);
        check_eq("single_wr_id", last_wr_id, 2'd3);

        // fairness with all requesters pending; also exercises the hold window
        apply_reset();
        n_gr = 0;
        for (int c = 0; c < 100; c++) begin
            step(4'b1111, $urandom);
            if (last_grant >= 0) begin
                check_eq("fair_order", last_grant, n_gr % 4);
                n_gr++;
            end
        end
        check_eq("fair_count", n_gr, 20);

        // pointer skip: move ptr to 2, then only 0/1 pending
        apply_reset();
        step(4'b0010, $urandom);
        repeat (4) step(4'b0000, 32'h0);
        step(4'b0011, $urandom);
        check_eq("skip_grant", last_grant, 0);
        repeat (4) step(4'b0000, 32'h0);
        step(4'b1111, $urandom);
        check_eq("skip_ptr", last_grant, 1);
        repeat (5) step(4'b0000, 32'h0);

        // RAW chain: r1 = r0 + r0, then r2 = r1 + r1 back-to-back
        apply_reset();
        x0 = 8'($urandom_range(1, 63));
        rf[0] = x0;
        rf[1] = 8'($urandom);
        rf[2] = 8'($urandom);
        step(4'b0001, {24'h0, mk_op(1, 0, 0, 0)});
        repeat (5) step(4'b0001, {24'h0, mk_op(2, 1, 1, 0)});
        check_eq("raw_r1", rf[1], 8'(2 * x0));
        repeat (5) step(4'b0000, 32'h0);
        check_eq("raw_wr_id", last_wr_id, 2'd2);
        check_eq("raw_wr_val", last_wr_val, 8'(4 * x0));

        // reset during EXE abandons the op
        apply_reset();
        step(4'b0100, $urandom);
        repeat (3) step(4'b0000, 32'h0);
        apply_reset();
        wr_before = wr_count;
        repeat (10) step(4'b0000, 32'h0);
        check_eq("rst_no_write", wr_count - wr_before, 0);

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            else step(4'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
